// File: rtl/ahbl_gpio_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter for the GPIO bus segment.
// Each master has a one-deep address holding stage; losers are stalled via HREADY.
module ahbl_gpio_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [1:0]        M0_HTRANS,
    input  logic [2:0]        M0_HSIZE,
    input  logic              M0_HWRITE,
    input  logic [31:0]       M0_HWDATA,
    output logic              M0_HREADY,
    output logic [31:0]       M0_HRDATA,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [1:0]        M1_HTRANS,
    input  logic [2:0]        M1_HSIZE,
    input  logic              M1_HWRITE,
    input  logic [31:0]       M1_HWDATA,
    output logic              M1_HREADY,
    output logic [31:0]       M1_HRDATA,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic [2:0]        S_HSIZE,
    output logic              S_HWRITE,
    output logic [31:0]       S_HWDATA,
    output logic              S_HSEL,
    output logic              S_HREADY,
    input  logic              S_HREADYOUT,
    input  logic [31:0]       S_HRDATA
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       RR            = (ARB_MODE != 0);

    logic              pend0_q, pend0_d;
    logic              pend1_q, pend1_d;
    logic [ADDR_W-1:0] hold0_addr_q, hold0_addr_d;
    logic [ADDR_W-1:0] hold1_addr_q, hold1_addr_d;
    logic [2:0]        hold0_size_q, hold0_size_d;
    logic [2:0]        hold1_size_q, hold1_size_d;
    logic              hold0_write_q, hold0_write_d;
    logic              hold1_write_q, hold1_write_d;
    owner_e            owner_q, owner_d;
    logic              last_q, last_d;

    logic m0_rdy, m1_rdy;
    logic live0, live1;
    logic req0, req1;
    logic pick1, any_gnt, gnt0, gnt1;
    logic unused_htrans;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, both of which collapse here
    assign unused_htrans = ^{M0_HTRANS[0], M1_HTRANS[0]};

    always_comb begin
        m0_rdy  = (owner_q == OWN_M0) ? S_HREADYOUT : ~pend0_q;
        m1_rdy  = (owner_q == OWN_M1) ? S_HREADYOUT : ~pend1_q;
        live0   = M0_HTRANS[1] & m0_rdy;
        live1   = M1_HTRANS[1] & m1_rdy;
        req0    = pend0_q | live0;
        req1    = pend1_q | live1;
        pick1   = req1 & (~req0 | (RR & ~last_q));
        any_gnt = HRESETn & S_HREADYOUT & (req0 | req1);
        gnt0    = any_gnt & ~pick1;
        gnt1    = any_gnt & pick1;
    end

    always_comb begin
        S_HADDR  = pend0_q ? hold0_addr_q  : M0_HADDR;
        S_HSIZE  = pend0_q ? hold0_size_q  : M0_HSIZE;
        S_HWRITE = pend0_q ? hold0_write_q : M0_HWRITE;
        if (pick1) begin
            S_HADDR  = pend1_q ? hold1_addr_q  : M1_HADDR;
            S_HSIZE  = pend1_q ? hold1_size_q  : M1_HSIZE;
            S_HWRITE = pend1_q ? hold1_write_q : M1_HWRITE;
        end
        S_HTRANS = any_gnt ? HTRANS_NONSEQ : HTRANS_IDLE;
        S_HSEL   = any_gnt;
    end

    always_comb begin
        case (owner_q)
            OWN_M0:  S_HWDATA = M0_HWDATA;
            OWN_M1:  S_HWDATA = M1_HWDATA;
            default: S_HWDATA = 32'h0;
        endcase
    end

    assign M0_HREADY = m0_rdy;
    assign M1_HREADY = m1_rdy;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign S_HREADY  = S_HREADYOUT;

    always_comb begin
        pend0_d       = pend0_q;
        pend1_d       = pend1_q;
        hold0_addr_d  = hold0_addr_q;
        hold0_size_d  = hold0_size_q;
        hold0_write_d = hold0_write_q;
        hold1_addr_d  = hold1_addr_q;
        hold1_size_d  = hold1_size_q;
        hold1_write_d = hold1_write_q;
        owner_d       = owner_q;
        last_d        = last_q;
        if (gnt0) begin
            pend0_d = 1'b0;
        end else if (live0) begin
            pend0_d       = 1'b1;
            hold0_addr_d  = M0_HADDR;
            hold0_size_d  = M0_HSIZE;
            hold0_write_d = M0_HWRITE;
        end
        if (gnt1) begin
            pend1_d = 1'b0;
        end else if (live1) begin
            pend1_d       = 1'b1;
            hold1_addr_d  = M1_HADDR;
            hold1_size_d  = M1_HSIZE;
            hold1_write_d = M1_HWRITE;
        end
        if (S_HREADYOUT) begin
            owner_d = gnt0 ? OWN_M0 : (gnt1 ? OWN_M1 : OWN_NONE);
        end
        if (any_gnt) begin
            last_d = gnt1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend0_q       <= 1'b0;
            pend1_q       <= 1'b0;
            hold0_addr_q  <= '0;
            hold0_size_q  <= '0;
            hold0_write_q <= 1'b0;
            hold1_addr_q  <= '0;
            hold1_size_q  <= '0;
            hold1_write_q <= 1'b0;
            owner_q       <= OWN_NONE;
            last_q        <= 1'b1;
        end else begin
            pend0_q       <= pend0_d;
            pend1_q       <= pend1_d;
            hold0_addr_q  <= hold0_addr_d;
            hold0_size_q  <= hold0_size_d;
            hold0_write_q <= hold0_write_d;
            hold1_addr_q  <= hold1_addr_d;
            hold1_size_q  <= hold1_size_d;
            hold1_write_q <= hold1_write_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
        end
    end

endmodule
